// File: rtl/rf_op_seq.sv
// Register-file initiator: read two operands, run one ALU op, write the result back.
// Optional define ALU_MUL_EN turns opcode 111 into a 16-cycle shift-add MUL; otherwise 111 is MOVB.
module rf_op_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [2:0]  req_ra,
    input  logic [2:0]  req_rb,
    input  logic [2:0]  req_rd,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    input  logic [15:0] d_out_a,
    input  logic [15:0] d_out_b,
    output logic        wr,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    output logic        done,
    output logic        flag_z,
    output logic        flag_c
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg, rd_reg;
    logic [2:0]  rd_addr_a_reg, rd_addr_b_reg, wr_addr_reg;
    logic [15:0] opa_reg, opb_reg, d_in_reg;
    logic        wr_reg, carry_reg, flag_z_reg, flag_c_reg;
    logic        accept, exec_done;
    logic [15:0] alu_res;
    logic        alu_c;
    logic [16:0] add_sum;
    logic [15:0] shl_stage [5];
    logic [15:0] shr_stage [5];

    // Log shifters: stage gi shifts by 2**gi when bit gi of the amount is set.
    assign shl_stage[0] = opa_reg;
    assign shr_stage[0] = opa_reg;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shift
            assign shl_stage[gi+1] = opb_reg[gi] ? (shl_stage[gi] << (2**gi)) : shl_stage[gi];
            assign shr_stage[gi+1] = opb_reg[gi] ? (shr_stage[gi] >> (2**gi)) : shr_stage[gi];
        end
    endgenerate

    assign add_sum = {1'b0, opa_reg} + {1'b0, opb_reg};

`ifdef ALU_MUL_EN
    logic [3:0]  mul_cnt_reg;
    logic [31:0] mul_acc_reg, mul_mcand_reg, mul_acc_next;
    logic [15:0] mul_mplier_reg;

    assign mul_acc_next = mul_acc_reg + (mul_mplier_reg[0] ? mul_mcand_reg : 32'd0);
    assign exec_done    = (op_reg != 3'b111) || (mul_cnt_reg == 4'd15);

    // One multiplier bit per EXEC cycle; operands are seeded while the file is being read.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_cnt_reg    <= '0;
            mul_acc_reg    <= '0;
            mul_mcand_reg  <= '0;
            mul_mplier_reg <= '0;
        end else if (state_reg == READ) begin
            mul_cnt_reg    <= '0;
            mul_acc_reg    <= '0;
            mul_mcand_reg  <= {16'd0, d_out_a};
            mul_mplier_reg <= d_out_b;
        end else if (state_reg == EXEC) begin
            mul_cnt_reg    <= mul_cnt_reg + 4'd1;
            mul_acc_reg    <= mul_acc_next;
            mul_mcand_reg  <= mul_mcand_reg << 1;
            mul_mplier_reg <= mul_mplier_reg >> 1;
        end
    end
`else
    assign exec_done = 1'b1;
`endif

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_reg)
            3'b000: {alu_c, alu_res} = add_sum;
            3'b001: begin
                alu_res = opa_reg - opb_reg;
                alu_c   = opa_reg < opb_reg;
            end
            3'b010: alu_res = opa_reg & opb_reg;
            3'b011: alu_res = opa_reg | opb_reg;
            3'b100: alu_res = opa_reg ^ opb_reg;
            3'b101: alu_res = shl_stage[4];
            3'b110: alu_res = shr_stage[4];
            default: begin
`ifdef ALU_MUL_EN
                alu_res = mul_acc_next[15:0];
                alu_c   = |mul_acc_next[31:16];
`else
                alu_res = opb_reg;
`endif
            end
        endcase
    end

    // Ready is masked by reset so nothing is accepted on a reset cycle.
    assign req_ready = (state_reg == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    if (exec_done) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg        <= '0;
            rd_reg        <= '0;
            rd_addr_a_reg <= '0;
            rd_addr_b_reg <= '0;
            wr_addr_reg   <= '0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            d_in_reg      <= '0;
            wr_reg        <= 1'b0;
            carry_reg     <= 1'b0;
            flag_z_reg    <= 1'b0;
            flag_c_reg    <= 1'b0;
        end else begin
            wr_reg <= (state_reg == EXEC) && exec_done;
            if (accept) begin
                op_reg        <= req_op;
                rd_reg        <= req_rd;
                rd_addr_a_reg <= req_ra;
                rd_addr_b_reg <= req_rb;
            end
            if (state_reg == READ) begin
                opa_reg <= d_out_a;
                opb_reg <= d_out_b;
            end
            // Write-port values settle on entry to WB and then hold until the next op.
            if ((state_reg == EXEC) && exec_done) begin
                d_in_reg    <= alu_res;
                carry_reg   <= alu_c;
                wr_addr_reg <= rd_reg;
            end
            if (state_reg == WB) begin
                flag_z_reg <= (d_in_reg == 16'd0);
                flag_c_reg <= carry_reg;
            end
        end
    end

    // Gating with reset keeps a WB cycle that coincides with reset from writing.
    assign wr        = wr_reg && !reset;
    assign done      = wr;
    assign wr_addr   = wr_addr_reg;
    assign d_in      = d_in_reg;
    assign rd_addr_a = rd_addr_a_reg;
    assign rd_addr_b = rd_addr_b_reg;
    assign flag_z    = flag_z_reg;
    assign flag_c    = flag_c_reg;

endmodule

// File: tb/tb_rf_op_seq.sv
// Bench for rf_op_seq: behavioural 8x16 register file plus an arithmetic reference model.
module tb_rf_op_seq;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready;
    logic [2:0]  req_op, req_ra, req_rb, req_rd;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] d_out_a, d_out_b, d_in;
    logic        wr, done, flag_z, flag_c;

    int checks   = 0;
    int failures = 0;

    logic [15:0] regs     [8];
    logic [15:0] exp_regs [8];
    logic        pl_en;
    logic [2:0]  pl_addr;
    logic [15:0] pl_data;
    logic        exp_z, exp_c;
    logic [15:0] res;

    rf_op_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_ra(req_ra), .req_rb(req_rb), .req_rd(req_rd),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .d_out_a(d_out_a), .d_out_b(d_out_b),
        .wr(wr), .wr_addr(wr_addr), .d_in(d_in), .done(done),
        .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    // Register file model; the preload port is only used while the sequencer is idle.
    always @(posedge clk) begin
        if (wr) regs[wr_addr] <= d_in;
        else if (pl_en) regs[pl_addr] <= pl_data;
    end
    assign d_out_a = regs[rd_addr_a];
    assign d_out_b = regs[rd_addr_b];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {(a < b), 16'(a - b)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, 16'(a << b[3:0])};
            3'd6: return {1'b0, 16'(a >> b[3:0])};
            default: begin
`ifdef ALU_MUL_EN
                p = 32'(a) * 32'(b);
                return {(p[31:16] != 16'd0), p[15:0]};
`else
                p = 32'd0;
                return {p[0], b};
`endif
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op);
`ifdef ALU_MUL_EN
        if (op == 3'd7) return 18;
`endif
        return (op == 3'd7) ? 3 : 3;
    endfunction

    // Called and returns on a falling edge.
    task automatic preload(input logic [2:0] addr, input logic [15:0] data);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        exp_regs[addr] = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one op; returns on the falling edge of the first IDLE cycle afterwards.
    task automatic run_op(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [2:0] rd, input bit hold, output logic [15:0] got);
        logic [16:0] r;
        int lat;
        r   = ref_alu(op, exp_regs[ra], exp_regs[rb]);
        lat = latency(op);
        got = 16'hxxxx;
        req_valid = 1'b1; req_op = op; req_ra = ra; req_rb = rb; req_rd = rd;
        #1 check("ready_at_accept", req_ready, 1);
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k <= lat) begin
                req_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
                req_op = 3'($urandom); req_ra = 3'($urandom);
                req_rb = 3'($urandom); req_rd = 3'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            check("wr_timing", wr, k == lat);
            check("done_timing", done, k == lat);
            check("ready_timing", req_ready, k == lat + 1);
            if (k == lat) begin
                got = d_in;
                check("wr_addr", wr_addr, rd);
                check("d_in", d_in, r[15:0]);
                check("flag_z_before_wb", flag_z, exp_z);
                check("flag_c_before_wb", flag_c, exp_c);
            end
            if (k == lat + 1) begin
                check("flag_z", flag_z, r[15:0] == 16'd0);
                check("flag_c", flag_c, r[16]);
                check("d_in_hold", d_in, r[15:0]);
                check("reg_written", regs[rd], r[15:0]);
            end
        end
        exp_regs[rd] = r[15:0];
        exp_z = (r[15:0] == 16'd0);
        exp_c = r[16];
        $display("op=%0d ra=%0d rb=%0d rd=%0d res=%h c=%0d hold=%0d", op, ra, rb, rd, r[15:0], r[16], hold);
    endtask

    // Start an op and hit reset during cycle abort_k (2 = EXEC, 3 = WB for short ops).
    task automatic run_abort(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                             input logic [2:0] rd, input int abort_k);
        req_valid = 1'b1; req_op = op; req_ra = ra; req_rb = rb; req_rd = rd;
        @(posedge clk);
        for (int k = 1; k < abort_k; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1 check("abort_pre_wr", wr, 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_ready_in_reset", req_ready, 0);
        check("abort_wr_in_reset", wr, 0);
        @(negedge clk);
        check("abort_wr_after", wr, 0);
        check("abort_done_after", done, 0);
        check("abort_d_in", d_in, 0);
        check("abort_wr_addr", wr_addr, 0);
        check("abort_rd_addr_a", rd_addr_a, 0);
        check("abort_flags", {flag_z, flag_c}, 0);
        reset = 1'b0;
        exp_z = 1'b0;
        exp_c = 1'b0;
        #1 check("abort_ready_release", req_ready, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_wr", wr, 0);
        end
        check("abort_reg_kept", regs[rd], exp_regs[rd]);
        $display("abort op=%0d rd=%0d at_cycle=%0d", op, rd, abort_k);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        req_op = '0; req_ra = '0; req_rb = '0; req_rd = '0;
        exp_z = 1'b0; exp_c = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_wr", wr, 0);
        check("rst_done", done, 0);
        check("rst_d_in", d_in, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_rd_addr", {rd_addr_a, rd_addr_b}, 0);
        check("rst_flags", {flag_z, flag_c}, 0);
        reset = 1'b0;
        #1 check("ready_after_rst", req_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));

        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        run_op(3'd0, 3'd1, 3'd2, 3'd3, 1'b0, res);
        check("add_const", res, 16'h8000);

        preload(3'd1, 16'h0003);
        preload(3'd2, 16'h0005);
        run_op(3'd1, 3'd1, 3'd2, 3'd1, 1'b0, res);
        check("sub_borrow_const", {flag_c, res}, 17'h1FFFE);
        preload(3'd1, 16'h0005);
        run_op(3'd1, 3'd1, 3'd2, 3'd1, 1'b0, res);
        check("sub_zero_const", {flag_z, flag_c, res}, 18'h20000);

        // Back-to-back with req_valid held high and junk fields mid-op.
        run_op(3'd2, 3'd3, 3'd4, 3'd5, 1'b1, res);
        run_op(3'd3, 3'd5, 3'd6, 3'd7, 1'b1, res);
        run_op(3'd4, 3'd7, 3'd7, 3'd0, 1'b1, res);
        run_op(3'd7, 3'd0, 3'd1, 3'd2, 1'b1, res);
        run_op(3'd0, 3'd2, 3'd2, 3'd2, 1'b1, res);

        preload(3'd4, 16'h8001);
        preload(3'd5, 16'h0011);
        run_op(3'd5, 3'd4, 3'd5, 3'd6, 1'b0, res);
        check("shl_const", res, 16'h0002);
        preload(3'd4, 16'h8000);
        preload(3'd5, 16'h000F);
        run_op(3'd6, 3'd4, 3'd5, 3'd6, 1'b0, res);
        check("shr_const", res, 16'h0001);

        preload(3'd1, 16'h0100);
        preload(3'd2, 16'h0101);
        run_op(3'd7, 3'd1, 3'd2, 3'd3, 1'b0, res);
`ifdef ALU_MUL_EN
        check("mul_const", {flag_c, res}, 17'h10100);
`else
        check("movb_const", res, 16'h0101);
`endif

        preload(3'd6, 16'h1234);
        preload(3'd7, 16'h0101);
        run_abort(3'd0, 3'd6, 3'd7, 3'd6, 2);
        run_abort(3'd0, 3'd6, 3'd7, 3'd6, 3);
        run_op(3'd0, 3'd6, 3'd7, 3'd6, 1'b0, res);
        check("post_abort_add", res, 16'h1335);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) preload(3'($urandom), 16'($urandom));
            run_op(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                   1'($urandom_range(0, 1)), res);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
